// File: rtl/alu_multicycle_if.sv
// Operand/result bundle between the control unit and alu_multicycle.
// The control unit drives start/control/a/b; the ALU drives the status and result lines.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [12:0]        control;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] c;
  logic               illegal;
  logic               div0;

  modport master (
    output start, control, a, b,
    input  busy, done, c, illegal, div0
  );

  modport slave (
    input  start, control, a, b,
    output busy, done, c, illegal, div0
  );
endinterface

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle logic/arith/shift ops, iterative WIDTH-step MUL and DIV.
// Define ALU_SIGNED_MULDIV_EN for two's-complement MUL/DIV; otherwise they are unsigned.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  alu_multicycle_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CntLast = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q, opnd_q;
  logic [12:0]        ctrl_q;
  logic [SHW:0]       cnt_q;
  logic [2*WIDTH-1:0] c_q, result_d;
  logic               illegal_q, div0_q, div0_d;

  logic               legal, is_mul, is_div, multi, exec_last;
  logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, quo, rem;
  logic [2*WIDTH-1:0] prod_raw, prod;

  assign legal     = (ctrl_q != '0) && ((ctrl_q & (ctrl_q - 13'd1)) == '0);
  assign is_mul    = legal && ctrl_q[4];
  assign is_div    = legal && ctrl_q[5];
  assign multi     = is_mul || is_div;
  // Setup cycle at count 0, then WIDTH iteration cycles at counts 1..WIDTH.
  assign exec_last = (state_q == StExec) && (!multi || (cnt_q == CntLast));

  // One shift-add (MUL) or restoring-subtract (DIV) step on {hi_q, lo_q}.
  logic [WIDTH:0] mul_sum, div_shift;
  logic           take;
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    take      = div_shift >= {1'b0, opnd_q};
    if (is_mul) begin
      step_hi = lo_q[0] ? mul_sum[WIDTH:1] : {1'b0, hi_q[WIDTH-1:1]};
      step_lo = {lo_q[0] ? mul_sum[0] : hi_q[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = take ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], take};
    end
  end

  assign prod_raw = {step_hi, step_lo};

`ifdef ALU_SIGNED_MULDIV_EN
  logic a_neg, b_neg;
  assign a_neg = a_q[WIDTH-1];
  assign b_neg = b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign prod  = (a_neg ^ b_neg) ? -prod_raw : prod_raw;
  assign quo   = (a_neg ^ b_neg) ? -step_lo : step_lo;
  assign rem   = a_neg ? -step_hi : step_hi;
`else
  assign a_mag = a_q;
  assign b_mag = b_q;
  assign prod  = prod_raw;
  assign quo   = step_lo;
  assign rem   = step_hi;
`endif

  logic [SHW-1:0]   sh;
  logic             sh_big;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_dif, neg_val, sra_val;
  logic [2*WIDTH-1:0] ror_val, rol_val;
  always_comb begin
    result_d = '0;
    div0_d   = 1'b0;
    sh       = b_q[SHW-1:0];
    sh_big   = |b_q[WIDTH-1:SHW];
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_dif  = a_q - b_q;
    neg_val  = -a_q;
    sra_val  = sh_big ? {WIDTH{a_q[WIDTH-1]}} : WIDTH'($signed(a_q) >>> sh);
    ror_val  = {a_q, a_q} >> sh;
    rol_val  = {a_q, a_q} << sh;
    if (legal) begin
      unique case (1'b1)
        ctrl_q[0]:  result_d = {{WIDTH{1'b0}}, a_q & b_q};
        ctrl_q[1]:  result_d = {{WIDTH{1'b0}}, a_q | b_q};
        ctrl_q[2]:  result_d = {{(WIDTH-1){1'b0}}, add_sum};
        ctrl_q[3]:  result_d = {{WIDTH{sub_dif[WIDTH-1]}}, sub_dif};
        ctrl_q[4]:  result_d = prod;
        ctrl_q[5]: begin
          if (b_q == '0) begin
            result_d = {a_q, {WIDTH{1'b1}}};
            div0_d   = 1'b1;
          end else begin
            result_d = {rem, quo};
          end
        end
        ctrl_q[6]:  result_d = sh_big ? '0 : {{WIDTH{1'b0}}, a_q >> sh};
        ctrl_q[7]:  result_d = {{WIDTH{1'b0}}, sra_val};
        ctrl_q[8]:  result_d = sh_big ? '0 : {{WIDTH{1'b0}}, a_q << sh};
        ctrl_q[9]:  result_d = {{WIDTH{1'b0}}, ror_val[WIDTH-1:0]};
        ctrl_q[10]: result_d = {{WIDTH{1'b0}}, rol_val[2*WIDTH-1:WIDTH]};
        ctrl_q[11]: result_d = {{WIDTH{neg_val[WIDTH-1]}}, neg_val};
        ctrl_q[12]: result_d = {{WIDTH{1'b0}}, ~a_q};
        default:    result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StExec;
      StExec:  if (exec_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q == StExec);
    bus.done    = (state_q == StDone);
    bus.c       = c_q;
    bus.illegal = bus.done && illegal_q;
    bus.div0    = bus.done && div0_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      c_q       <= '0;
      illegal_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      if ((state_q == StIdle) && bus.start) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        ctrl_q    <= bus.control;
        cnt_q     <= '0;
        illegal_q <= 1'b0;
        div0_q    <= 1'b0;
      end
      if (state_q == StExec) begin
        cnt_q <= cnt_q + CntOne;
        if (multi) begin
          if (cnt_q == '0) begin
            hi_q   <= '0;
            lo_q   <= is_mul ? b_mag : a_mag;
            opnd_q <= is_mul ? a_mag : b_mag;
          end else begin
            hi_q <= step_hi;
            lo_q <= step_lo;
          end
        end
        if (exec_last) begin
          c_q       <= result_d;
          illegal_q <= !legal;
          div0_q    <= div0_d;
        end
      end
    end
  end
endmodule
